// File: rtl/gray_pkg.sv
// Shared types and helpers for the shared Gray-to-binary converter arbiter.
// Builds with or without GRAY_CONV_ARB_CNT_EN; nothing in this package depends on it.
package gray_pkg;

  localparam int CNT_W = 16;

  typedef enum logic {EMPTY, FULL} arb_state_t;

  // Index width that never collapses to zero bits, even for a single requester
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary converter: bin[k] is the XOR of gray[SIZE-1:k].
module gray2bin #(
  parameter int SIZE = 8
) (
  input  logic [SIZE-1:0] gray,
  output logic [SIZE-1:0] bin
);

  always_comb begin
    bin = '0;
    for (int k = 0; k < SIZE; k++) begin
      bin[k] = ^(gray >> k);
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin grant picker: the first asserted request at or after ptr, wrapping modulo N.
// Outputs a one-hot grant and the matching index; both are zero when nothing requests.
module rr_arbiter import gray_pkg::*; #(
  parameter  int N  = 4,
  localparam int IW = id_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && req[(int'(ptr) + k) % N]) begin
        found                    = 1'b1;
        gnt[(int'(ptr) + k) % N] = 1'b1;
        idx                      = IW'((int'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/gray_conv_arbiter.sv
// One gray2bin converter shared by NREQ requesters behind a round-robin arbiter and a single response register.
// Define GRAY_CONV_ARB_CNT_EN to add the rsp_count completed-transfer counter output.
module gray_conv_arbiter import gray_pkg::*; #(
  parameter  int SIZE = 8,
  parameter  int NREQ = 4,
  localparam int IDW  = id_width(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*SIZE-1:0] req_gray,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rsp_valid,
  output logic [SIZE-1:0]      rsp_bin,
  output logic [IDW-1:0]       rsp_id,
  input  logic                 rsp_ready
`ifdef GRAY_CONV_ARB_CNT_EN
  ,
  output logic [CNT_W-1:0]     rsp_count
`endif
);

  arb_state_t       state_q, state_d;
  logic [IDW-1:0]   ptr_q;
  logic [NREQ-1:0]  gnt;
  logic [IDW-1:0]   gnt_idx;
  logic             out_free;
  logic             xfer;
  logic [SIZE-1:0]  gray_p0, bin_p0;
  logic [SIZE-1:0]  bin_p1;
  logic [IDW-1:0]   id_p1;
  logic             vld_p1;

  // Stage p0: arbitration and conversion of the granted operand
  rr_arbiter #(.N(NREQ)) u_rr (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (gnt),
    .idx (gnt_idx)
  );

  assign vld_p1    = (state_q == FULL);
  assign out_free  = !vld_p1 || rsp_ready;
  assign req_ready = (out_free && rst_n) ? gnt : '0;
  assign xfer      = |(req_valid & req_ready);
  assign gray_p0   = req_gray[int'(gnt_idx)*SIZE +: SIZE];

  gray2bin #(.SIZE(SIZE)) u_conv (
    .gray (gray_p0),
    .bin  (bin_p0)
  );

  always_comb begin
    state_d = state_q;
    if (xfer)           state_d = FULL;
    else if (rsp_ready) state_d = EMPTY;
  end

  // Stage p1: response register, loaded only on an accepted request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
      bin_p1  <= '0;
      id_p1   <= '0;
    end else begin
      state_q <= state_d;
      if (xfer) begin
        bin_p1 <= bin_p0;
        id_p1  <= gnt_idx;
        ptr_q  <= (int'(gnt_idx) == NREQ-1) ? '0 : gnt_idx + IDW'(1);
      end
    end
  end

  assign rsp_valid = vld_p1;
  assign rsp_bin   = bin_p1;
  assign rsp_id    = id_p1;

`ifdef GRAY_CONV_ARB_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    cnt_q <= '0;
    else if (xfer) cnt_q <= cnt_q + CNT_W'(1);
  end

  assign rsp_count = cnt_q;
`endif

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Directed bench for gray_conv_arbiter (SIZE=5, NREQ=4); counter checks run when GRAY_CONV_ARB_CNT_EN is defined.
module tb_gray_conv_arbiter;

  localparam int SIZE = 5;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ*SIZE-1:0] req_gray = '0;
  logic [NREQ-1:0]      req_ready;
  logic                 rsp_valid;
  logic [SIZE-1:0]      rsp_bin;
  logic [IDW-1:0]       rsp_id;
  logic                 rsp_ready = 1'b0;
`ifdef GRAY_CONV_ARB_CNT_EN
  logic [15:0]          rsp_count;
`endif

  int checks = 0;
  int errors = 0;

  gray_conv_arbiter #(.SIZE(SIZE), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_gray  (req_gray),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_bin   (rsp_bin),
    .rsp_id    (rsp_id),
    .rsp_ready (rsp_ready)
`ifdef GRAY_CONV_ARB_CNT_EN
    ,
    .rsp_count (rsp_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one active edge, then settle inputs/outputs away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int          exp_id [5]  = '{0, 1, 2, 3, 0};
  logic [4:0]  exp_bin [5] = '{5'b00001, 5'b11111, 5'b10101, 5'b00000, 5'b00001};
  logic [3:0]  exp_rdy [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    // 1: reset state, including req_ready gated while reset is held
    req_valid = 4'b1111;
    #12;
    chk("rst_rdy", 32'(req_ready), 32'h0);
    chk("rst_vld", 32'(rsp_valid), 32'h0);
    chk("rst_bin", 32'(rsp_bin), 32'h0);
    req_valid = '0;
    rst_n = 1'b1;
    tick();
    chk("idle_vld", 32'(rsp_valid), 32'h0);
    chk("idle_rdy", 32'(req_ready), 32'h0);

    // 2: single requester 2
    rsp_ready = 1'b1;
    req_gray[2*SIZE +: SIZE] = 5'b10000;
    req_valid = 4'b0100;
    #1;
    chk("single_rdy", 32'(req_ready), 32'b0100);
    tick();
    req_valid = '0;
    chk("single_vld", 32'(rsp_valid), 32'h1);
    chk("single_bin", 32'(rsp_bin), 32'b11111);
    chk("single_id", 32'(rsp_id), 32'd2);
    tick();
    chk("drain_vld", 32'(rsp_valid), 32'h0);

    // 3: restart from pointer 0, all four continuously valid
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    req_gray = {5'b00000, 5'b11111, 5'b10000, 5'b00001};
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("rr_rdy%0d", i), 32'(req_ready), 32'(exp_rdy[i]));
      tick();
      chk($sformatf("rr_vld%0d", i), 32'(rsp_valid), 32'h1);
      chk($sformatf("rr_id%0d", i), 32'(rsp_id), 32'(exp_id[i]));
      chk($sformatf("rr_bin%0d", i), 32'(rsp_bin), 32'(exp_bin[i]));
    end

    // 4: backpressure holds response and freezes pointer at 1
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("hold_rdy%0d", i), 32'(req_ready), 32'h0);
      tick();
      chk($sformatf("hold_id%0d", i), 32'(rsp_id), 32'd0);
      chk($sformatf("hold_bin%0d", i), 32'(rsp_bin), 32'b00001);
      chk($sformatf("hold_vld%0d", i), 32'(rsp_valid), 32'h1);
    end
    rsp_ready = 1'b1;
    #1;
    chk("resume_rdy", 32'(req_ready), 32'b0010);
    tick();
    chk("resume_id", 32'(rsp_id), 32'd1);
    chk("resume_bin", 32'(rsp_bin), 32'b11111);

    // Pointer at 2: requester 2 dropped, so 3 is granted, then wrap to 0
    req_valid = 4'b1001;
    #1;
    chk("skip_rdy", 32'(req_ready), 32'b1000);
    tick();
    chk("skip_id", 32'(rsp_id), 32'd3);
    chk("skip_bin", 32'(rsp_bin), 32'b00000);
    #1;
    chk("wrap_rdy", 32'(req_ready), 32'b0001);
    tick();
    chk("wrap_id", 32'(rsp_id), 32'd0);

    // 5: reset while FULL and holding
    req_valid = '0;
    rsp_ready = 1'b0;
    tick();
    chk("prerst_vld", 32'(rsp_valid), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_vld", 32'(rsp_valid), 32'h0);
    chk("midrst_bin", 32'(rsp_bin), 32'h0);
    chk("midrst_id", 32'(rsp_id), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    #1;
    chk("restart_rdy", 32'(req_ready), 32'b0001);
    tick();
    chk("restart_id", 32'(rsp_id), 32'd0);

    // Single active requester is granted every cycle
    req_valid = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("solo_rdy%0d", i), 32'(req_ready), 32'b0010);
      tick();
      chk($sformatf("solo_id%0d", i), 32'(rsp_id), 32'd1);
    end
    req_valid = '0;

`ifdef GRAY_CONV_ARB_CNT_EN
    // 6: five transfers since the last reset, then wrap from FFFF
    chk("cnt_five", 32'(rsp_count), 32'd5);
    force dut.cnt_q = 16'hFFFF;
    #1;
    release dut.cnt_q;
    chk("cnt_forced", 32'(rsp_count), 32'hFFFF);
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    chk("cnt_wrap", 32'(rsp_count), 32'd0);
`endif

    tick();
    chk("end_vld", 32'(rsp_valid), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
